tvm_fare_initiator: RTL and testbench

- Host-side transmitter that drives the fare machine's request interface, the counterpart to the tf_rmm receiver.
- On a start pulse it frames one transaction: ready assert, fee byte, money byte, release. It then waits for the machine's response and captures the result and change amount.
- Sits between the user/keypad front-end and the tf_rmm core. Provides a response timeout.

---
 rtl/tvm_fare_initiator.sv | 108 ++++++++++
 tb/tb_tvm_fare_initiator.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/tvm_fare_initiator.sv
// tvm_fare_initiator: frames one fee/money request to the fare machine and captures its response
module tvm_fare_initiator #(
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] fee,
   input  logic [DATA_W-1:0] money,
   output logic              in_RDY5,
   output logic [DATA_W-1:0] DATA_in5,
   input  logic              out_RDY5,
   input  logic              state_cmp5,
   input  logic [DATA_W-1:0] DATA_out5,
   output logic              busy,
   output logic              done,
   output logic              accepted,
   output logic [DATA_W-1:0] change,
   output logic              timeout
);
   typedef enum logic [2:0] {
      S_IDLE, S_ASSERT, S_SEND_FEE, S_SEND_MONEY, S_RELEASE, S_WAIT_RSP, S_DONE, S_ABORT
   } state_t;
   state_t            r_state;
   logic [DATA_W-1:0] r_fee;
   logic [DATA_W-1:0] r_money;
   logic [CNT_W-1:0]  r_cnt;
   // Sequencer: each state registers its bus/status outputs on the edge it is left
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_fee    <= '0;
         r_money  <= '0;
         r_cnt    <= '0;
         in_RDY5  <= 1'b0;
         DATA_in5 <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         timeout  <= 1'b0;
         accepted <= 1'b0;
         change   <= '0;
      end else begin
         done    <= 1'b0;
         timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               in_RDY5  <= 1'b0;
               DATA_in5 <= '0;
               if (start) begin
                  r_fee    <= fee;
                  r_money  <= money;
                  busy     <= 1'b1;
                  accepted <= 1'b0;
                  change   <= '0;
                  r_state  <= S_ASSERT;
               end
            end
            S_ASSERT: begin
               in_RDY5  <= 1'b1;
               DATA_in5 <= '0;
               r_state  <= S_SEND_FEE;
            end
            S_SEND_FEE: begin
               in_RDY5  <= 1'b1;
               DATA_in5 <= r_fee;
               r_state  <= S_SEND_MONEY;
            end
            S_SEND_MONEY: begin
               in_RDY5  <= 1'b1;
               DATA_in5 <= r_money;
               r_state  <= S_RELEASE;
            end
            S_RELEASE: begin
               in_RDY5  <= 1'b0;
               DATA_in5 <= '0;
               r_cnt    <= '0;
               r_state  <= S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
               if (out_RDY5) begin
                  accepted <= state_cmp5;
                  change   <= DATA_out5;
                  r_state  <= S_DONE;
               end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                  r_state  <= S_ABORT;
               end else begin
                  r_cnt    <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            S_ABORT: begin
               timeout  <= 1'b1;
               busy     <= 1'b0;
               accepted <= 1'b0;
               change   <= '0;
               r_state  <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tvm_fare_initiator.sv
// tb_tvm_fare_initiator: randomized transactions checked against a timeline model of the request/response protocol
module tb_tvm_fare_initiator;
   localparam int W = 8;
   localparam int T = 16;
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] fee = '0;
   logic [W-1:0] money = '0;
   logic         in_RDY5;
   logic [W-1:0] DATA_in5;
   logic         out_RDY5 = 1'b0;
   logic         state_cmp5 = 1'b0;
   logic [W-1:0] DATA_out5 = '0;
   logic         busy;
   logic         done;
   logic         accepted;
   logic [W-1:0] change;
   logic         timeout;
   int           n_tests = 0;
   int           n_fail = 0;

   tvm_fare_initiator #(.DATA_W(W), .TIMEOUT(T), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .start(start), .fee(fee), .money(money),
      .in_RDY5(in_RDY5), .DATA_in5(DATA_in5), .out_RDY5(out_RDY5),
      .state_cmp5(state_cmp5), .DATA_out5(DATA_out5), .busy(busy), .done(done),
      .accepted(accepted), .change(change), .timeout(timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One transaction. k = WAIT edge (1..T) on which the machine answers; k > T means no answer.
   // poke = pulse start during SEND_FEE and during the DONE cycle; both must be ignored.
   task automatic txn(input logic [W-1:0] f, input logic [W-1:0] m, input int k,
                      input logic c, input logic [W-1:0] d, input bit poke);
      logic [W-1:0] exp_dat[4];
      logic         exp_rdy[4];
      bit           answered;
      int           last;
      answered = (k >= 1 && k <= T);
      last = answered ? k : T;
      exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b0};
      exp_dat = '{'0, f, m, '0};
      fee = f;
      money = m;
      start = 1'b1;
      step();
      start = 1'b0;
      fee = W'($urandom);
      money = W'($urandom);
      chk("busy_accept", busy, 1);
      chk("acc_cleared", accepted, 0);
      chk("chg_cleared", change, 0);
      for (int i = 0; i < 4; i++) begin
         start = poke && i == 1;
         out_RDY5 = 1'($urandom);
         state_cmp5 = 1'($urandom);
         DATA_out5 = W'($urandom);
         step();
         chk("frame_rdy", in_RDY5, exp_rdy[i]);
         chk("frame_dat", DATA_in5, exp_dat[i]);
      end
      start = 1'b0;
      for (int j = 1; j <= last; j++) begin
         out_RDY5 = (j == k);
         state_cmp5 = (j == k) ? c : 1'($urandom);
         DATA_out5 = (j == k) ? d : W'($urandom);
         step();
         chk("wait_done", done, 0);
         chk("wait_tmo", timeout, 0);
         chk("wait_busy", busy, 1);
         chk("wait_rdy", in_RDY5, 0);
      end
      out_RDY5 = 1'b0;
      start = poke && answered;
      step();
      start = 1'b0;
      chk("end_done", done, answered);
      chk("end_tmo", timeout, !answered);
      chk("end_busy", busy, 0);
      chk("end_acc", accepted, answered ? c : 1'b0);
      chk("end_chg", change, answered ? d : '0);
      out_RDY5 = 1'b1;
      state_cmp5 = ~c;
      DATA_out5 = ~d;
      step();
      out_RDY5 = 1'b0;
      chk("idle_done", done, 0);
      chk("idle_tmo", timeout, 0);
      chk("idle_busy", busy, 0);
      chk("idle_rdy", in_RDY5, 0);
      chk("hold_acc", accepted, answered ? c : 1'b0);
      chk("hold_chg", change, answered ? d : '0);
   endtask

   initial begin
      start = 1'b1;
      step();
      step();
      chk("rst_rdy", in_RDY5, 0);
      chk("rst_dat", DATA_in5, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_tmo", timeout, 0);
      chk("rst_acc", accepted, 0);
      chk("rst_chg", change, 0);
      start = 1'b0;
      rst = 1'b1;
      step();
      step();
      chk("post_rst_busy", busy, 0);
      chk("post_rst_rdy", in_RDY5, 0);
      txn(8'h1E, 8'h05, 1, 1'b0, 8'h05, 1'b0);
      txn(8'h1E, 8'h1E, 4, 1'b1, 8'h00, 1'b0);
      txn(8'h33, 8'h44, T + 1, 1'b1, 8'hAA, 1'b0);
      txn(8'h12, 8'h34, T, 1'b1, 8'hC3, 1'b0);
      txn(8'h56, 8'h78, 2, 1'b1, 8'h9A, 1'b1);
      fee = 8'hA5;
      money = 8'h5A;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
      chk("midrst_rdy", in_RDY5, 0);
      chk("midrst_dat", DATA_in5, 0);
      chk("midrst_busy", busy, 0);
      rst = 1'b1;
      step();
      txn(8'hA5, 8'h5A, 3, 1'b0, 8'hFF, 1'b0);
      for (int r = 0; r < 20; r++)
         txn(W'($urandom), W'($urandom), int'($urandom_range(1, T + 2)), 1'($urandom),
             W'($urandom), 1'($urandom));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
